rr_stream_arbiter: RTL
======================

Name: rr_stream_arbiter

Overview:
- N-to-1 round-robin arbiter sharing one downstream valid/ready consumer (typically a `queue` instance feeding a shared pipeline port) between N requesters.
- Multi-beat packets are delimited by a `last` flag; the grant locks to one source until its last beat is accepted.
- Sits between per-unit producers (e.g. several issue/writeback sources) and a single shared queue or datapath port.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- WIDTH, 32, payload width in bits.
- SRC_W, $clog2(N), width of the source-index field (derived; do not override).

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- flush  input  1  synchronous abort: drop lock, reset priority
- in_valid  input  N  per-requester valid
- in_ready  output  N  per-requester ready
- in_data  input  N*WIDTH  per-requester payload; requester i occupies bits [i*WIDTH +: WIDTH]
- in_last  input  N  per-requester last-beat flag
- out_valid  output  1  downstream valid
- out_ready  input  1  downstream ready
- out_data  output  WIDTH  granted payload
- out_last  output  1  granted last flag
- out_src  output  SRC_W  index of the granted requester
- locked  output  1  high while a multi-beat packet is in progress

Behaviour:
- State: `st` ∈ {IDLE, LOCKED}; `ptr` (SRC_W bits) is the highest-priority index; `owner` (SRC_W bits) is the locked source.
- Reset (async): st=IDLE, ptr=0, owner=0, locked=0. All other outputs are combinational from state and inputs.
- Zero-latency datapath; no storage. out_* and in_ready are combinational.
- IDLE grant selection:
  - gidx = first i in ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N) with in_valid[i]=1.
  - out_valid = |in_valid.
  - When no requester is valid: out_src=0, out_data=0, out_last=0.
- LOCKED grant selection: gidx = owner, out_valid = in_valid[owner]. Other requesters are not granted even if valid.
- out_data = in_data[gidx], out_last = in_last[gidx], out_src = gidx.
- in_ready[i] = out_ready && out_valid && (i == gidx); all other bits are 0. Exactly one or zero beats transfer per cycle.
- fire = out_valid && out_ready.
- Transitions, applied only when flush=0:
  - IDLE, fire, out_last=0 → LOCKED, owner <= gidx; ptr is unchanged.
  - IDLE, fire, out_last=1 → stay IDLE, ptr <= (gidx+1) mod N.
  - LOCKED, fire, out_last=1 → IDLE, ptr <= (owner+1) mod N.
  - LOCKED, fire, out_last=0, or no fire → hold.
- ptr increment wraps modulo N, including non-power-of-2 N: N-1 → 0.
- locked = (st == LOCKED), registered.
- flush:
  - Next state is st=IDLE, ptr=0 regardless of fire.
  - Combinational grant in the flush cycle still follows current state; a beat accepted in that cycle counts as transferred.
- Fairness: with all N requesters continuously valid and single-beat packets, grants rotate 0,1,…,N-1 with no source granted twice before every other valid source is granted once.
- A requester dropping in_valid mid-packet while LOCKED stalls the output; the lock is held and no other source is granted. Requesters must not do this except under flush.
- Reset asserted mid-packet: lock is lost immediately; no recovery of the partial packet.

Test Plan:
- Reset, then in_valid=4'b1111, all in_last=1, out_ready=1 for 8 cycles → out_src sequence 0,1,2,3,0,1,2,3; in_ready one-hot matching out_src.
- ptr=2 (after one grant to src1), in_valid=4'b1001 → grant src3, then src0; src0 is not granted first.
- src1 sends 3 beats (last on beat 3, data 0xA1, 0xA2, 0xA3) while src2 is valid throughout → out_data A1, A2, A3 from src1 consecutively, locked=1 after beat 1 until beat 3 accepted; src2 granted next cycle.
- Same 3-beat packet with out_ready=0 for 2 cycles after beat 1 → out_data holds A2, in_ready=0, state stays LOCKED, no beat lost or duplicated.
- LOCKED on src3, assert flush for one cycle with out_ready=0 → next cycle locked=0, ptr=0; with in_valid=4'b1100, src2 is granted.
- N=3 parameterisation, all valid, single-beat → out_src 0,1,2,0; ptr wraps correctly from 2 to 0.

Source files
------------

// File: rtl/rr_stream_arbiter_if.sv
// Request/response bundle between N stream producers, the round-robin arbiter
// and the single downstream consumer it feeds.
interface rr_stream_arbiter_if #(
   parameter int N     = 4,
   parameter int WIDTH = 32,
   parameter int SRC_W = $clog2(N)
);
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_last;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic               out_last;
   logic [SRC_W-1:0]   out_src;
   logic               locked;

   // Arbiter side.
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, out_src, locked
   );

   // Environment side: producers plus the downstream consumer.
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_src, locked
   );
endinterface

// File: rtl/rr_stream_arbiter.sv
// N-to-1 round-robin stream arbiter with packet locking on a last flag.
// Zero-latency, storage-free datapath; only grant state is registered.
module rr_stream_arbiter #(
   parameter int N     = 4,
   parameter int WIDTH = 32,
   parameter int SRC_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   rr_stream_arbiter_if.slave bus
);
   typedef enum logic {IDLE, LOCKED} state_t;

   state_t           st;
   logic [SRC_W-1:0] ptr;
   logic [SRC_W-1:0] owner;
   logic [SRC_W-1:0] rr_idx;
   logic [SRC_W-1:0] gidx;
   logic             any_valid;
   logic             show;
   logic             fire;

   function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] x);
      return (x == SRC_W'(N - 1)) ? '0 : x + SRC_W'(1);
   endfunction

   // First valid requester scanning ptr, ptr+1, ... with wrap at N.
   always_comb begin
      logic found;
      int   j;
      // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
      found  = 1'b0;
      rr_idx = '0;
      j      = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!found && bus.in_valid[j]) begin
            found  = 1'b1;
            rr_idx = SRC_W'(j);
         end
      end
   end

   assign any_valid     = |bus.in_valid;
   assign gidx          = (st == LOCKED) ? owner : rr_idx;
   assign bus.out_valid = (st == LOCKED) ? bus.in_valid[owner] : any_valid;
   assign show          = (st == LOCKED) || any_valid;
   assign bus.out_src   = gidx;
   assign fire          = bus.out_valid && bus.out_ready;
   assign bus.locked    = (st == LOCKED);

   always_comb begin
      bus.out_data = '0;
      bus.out_last = 1'b0;
      bus.in_ready = '0;
      for (int i = 0; i < N; i++) begin
         if (show && SRC_W'(i) == gidx) begin
            bus.out_data = bus.in_data[i*WIDTH +: WIDTH];
            bus.out_last = bus.in_last[i];
         end
         bus.in_ready[i] = fire && (SRC_W'(i) == gidx);
      end
   end

   // NOTE: registered state uses non-blocking assignments and an asynchronous reset; there is no storage array to reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st    <= IDLE;
         ptr   <= '0;
         owner <= '0;
      end else if (flush) begin
         st  <= IDLE;
         ptr <= '0;
      end else begin
         case (st)
            IDLE: begin
               if (fire) begin
                  if (bus.out_last) begin
                     ptr <= wrap_inc(gidx);
                  end else begin
                     st    <= LOCKED;
                     owner <= gidx;
                  end
               end
            end
            LOCKED: begin
               // Lock releases only when the owner's last beat is accepted.
               if (fire && bus.out_last) begin
                  st  <= IDLE;
                  ptr <= wrap_inc(owner);
               end
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule
